// File: rtl/psram_wr_buf_if.sv
// psram_wr_buf_if: bundles the burst command, the write-beat channel, the
// core transfer channel and the status outputs of psram_wr_buf.
// Handshakes: a write beat moves on a rising edge with wr_valid_i && wr_ready_o,
// and a core request is taken on a rising edge with xfer_valid_o && xfer_ready_i.
// The sender keeps valid and its payload steady until that edge. xfer_done_i is
// a one-cycle completion strobe for the single request in flight.
interface psram_wr_buf_if #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = 8
);
    localparam int LEVEL_W = $clog2(DEPTH) + 1;

    logic                  start_i;
    logic [31:0]           addr_i;
    logic [7:0]            len_i;
    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic [MASK_WIDTH-1:0] wr_mask_i;
    logic                  wr_last_i;
    logic                  xfer_valid_o;
    logic                  xfer_ready_i;
    logic                  xfer_done_i;
    logic [31:0]           xfer_addr_o;
    logic [DATA_WIDTH-1:0] xfer_data_o;
    logic [MASK_WIDTH-1:0] xfer_mask_o;
    logic                  done_o;
    logic                  err_o;
    logic                  busy_o;
    logic [LEVEL_W-1:0]    level_o;
    logic [1:0]            state_o;

    modport master (
        output start_i, addr_i, len_i, wr_valid_i, wr_data_i, wr_mask_i, wr_last_i,
        output xfer_ready_i, xfer_done_i,
        input  wr_ready_o, xfer_valid_o, xfer_addr_o, xfer_data_o, xfer_mask_o,
        input  done_o, err_o, busy_o, level_o, state_o
    );

    modport slave (
        input  start_i, addr_i, len_i, wr_valid_i, wr_data_i, wr_mask_i, wr_last_i,
        input  xfer_ready_i, xfer_done_i,
        output wr_ready_o, xfer_valid_o, xfer_addr_o, xfer_data_o, xfer_mask_o,
        output done_o, err_o, busy_o, level_o, state_o
    );
endinterface

// File: rtl/psram_wr_buf.sv
// psram_wr_buf: queues the beats of one AXI write burst, issues one core
// transfer per beat at an incrementing address and pulses done_o after the
// last completion. state_o exposes the FSM state for debug.
// Optional feature macro PSRAM_WR_BUF_SKIP_EMPTY_EN: when defined, head beats
// with an all-zero byte mask are retired without a core transfer.
module psram_wr_buf #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
    input logic           clk_i,
    input logic           rst_n_i,
    psram_wr_buf_if.slave bus
);
    localparam int                 PTR_W      = $clog2(DEPTH);
    localparam int                 LEVEL_W    = PTR_W + 1;
    localparam logic [LEVEL_W-1:0] LEVEL_FULL = LEVEL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [31:0]           cur_addr_q, cur_addr_d;
    logic [7:0]            len_q, len_d;
    logic [8:0]            acc_cnt_q, acc_cnt_d;
    logic [8:0]            done_cnt_q, done_cnt_d;
    logic                  err_q, err_d;
    logic                  inflight_q, inflight_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]    level_q, level_d;

    // Beat storage is plain registers without reset; the pointers and level
    // decide which entries are meaningful.
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [MASK_WIDTH-1:0] mask_mem [DEPTH];

    logic                  run;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  present_ok;
    logic                  skip_pop;
    logic                  wr_ready;
    logic                  xfer_valid;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;
    logic [MASK_WIDTH-1:0] head_mask;

    // Handshake qualifiers; write readiness is decided before any pop this cycle
    always_comb begin
        run        = (state_q == ST_RUN);
        fifo_empty = (level_q == '0);
        fifo_full  = (level_q == LEVEL_FULL);
        head_data  = data_mem[rd_ptr_q];
        head_mask  = mask_mem[rd_ptr_q];
`ifdef PSRAM_WR_BUF_SKIP_EMPTY_EN
        present_ok = (head_mask != '0);
        skip_pop   = run && !fifo_empty && !inflight_q && (head_mask == '0);
`else
        present_ok = 1'b1;
        skip_pop   = 1'b0;
`endif
        wr_ready   = run && !fifo_full && (acc_cnt_q <= {1'b0, len_q});
        push       = wr_ready && bus.wr_valid_i;
        xfer_valid = run && !fifo_empty && !inflight_q && present_ok;
        pop        = run && ((inflight_q && bus.xfer_done_i) || skip_pop);
    end

    // FSM next state plus counter, pointer and flag updates
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        acc_cnt_d  = acc_cnt_q;
        done_cnt_d = done_cnt_q;
        err_d      = err_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    state_d    = ST_RUN;
                    cur_addr_d = bus.addr_i;
                    len_d      = bus.len_i;
                    acc_cnt_d  = '0;
                    done_cnt_d = '0;
                    err_d      = 1'b0;
                    inflight_d = 1'b0;
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    level_d    = '0;
                end
            end
            ST_RUN: begin
                if (push) begin
                    wr_ptr_d  = wr_ptr_q + PTR_W'(1);
                    acc_cnt_d = acc_cnt_q + 9'd1;
                    // A misplaced wlast is flagged but the beat is still kept
                    if (bus.wr_last_i != (acc_cnt_q == {1'b0, len_q})) begin
                        err_d = 1'b1;
                    end
                end
                if (xfer_valid && bus.xfer_ready_i) begin
                    inflight_d = 1'b1;
                end
                if (pop) begin
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    cur_addr_d = cur_addr_q + 32'd8;
                    done_cnt_d = done_cnt_q + 9'd1;
                    inflight_d = 1'b0;
                    if (done_cnt_q == {1'b0, len_q}) begin
                        state_d = ST_RESP;
                    end
                end
                case ({push, pop})
                    2'b10:   level_d = level_q + LEVEL_W'(1);
                    2'b01:   level_d = level_q - LEVEL_W'(1);
                    default: level_d = level_q;
                endcase
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and control registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            acc_cnt_q  <= '0;
            done_cnt_q <= '0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            acc_cnt_q  <= acc_cnt_d;
            done_cnt_q <= done_cnt_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
        end
    end

    // Beat storage write port
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wr_ptr_q] <= bus.wr_data_i;
            mask_mem[wr_ptr_q] <= bus.wr_mask_i;
        end
    end

    // The head entry stays put until it is popped, so the transfer payload is
    // stable while a request is offered or in flight. An empty FIFO shows zero.
    assign bus.wr_ready_o   = wr_ready;
    assign bus.xfer_valid_o = xfer_valid;
    assign bus.xfer_addr_o  = cur_addr_q;
    assign bus.xfer_data_o  = fifo_empty ? '0 : head_data;
    assign bus.xfer_mask_o  = fifo_empty ? '0 : head_mask;
    assign bus.done_o       = (state_q == ST_RESP);
    assign bus.err_o        = err_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
    assign bus.level_o      = level_q;
    assign bus.state_o      = state_q;
endmodule
